// File: rtl/acc_ctrl.sv
// acc_ctrl: read-modify-write accumulator over a word RAM with a streaming drain port
module acc_ctrl #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_valid_i,
  output logic        acc_ready_o,
  input  logic [10:0] acc_idx_i,
  input  logic [31:0] acc_data_i,
  input  logic        acc_first_i,
  input  logic        drain_start_i,
  input  logic [10:0] drain_base_i,
  input  logic [11:0] drain_len_i,
  output logic        drain_busy_o,
  output logic        drain_done_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [12:0] ram_w_addr_o,
  output logic [12:0] ram_r_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        sat_o
);
  typedef enum logic [2:0] {IDLE, ACC_RD, ACC_WR, DR_RD, DR_OUT, DR_DONE} state_t;
  state_t      state_q, state_d;
  logic        rdy_q;
  logic        ent_q;
  logic [10:0] idx_q, idx_d, ptr_q, ptr_d;
  logic [31:0] data_q, data_d, hold_q;
  logic        first_q, first_d;
  logic [11:0] rem_q, rem_d;
  logic        sat_q, sat_d;
  logic [31:0] sum, wsum;
  logic        ovf, start, acc_hs;
  // rdy_q holds ready low until the first edge after reset release
  assign start       = state_q == IDLE && rdy_q && drain_start_i;
  assign acc_ready_o = state_q == IDLE && rdy_q && !drain_start_i;
  assign acc_hs      = acc_valid_i && acc_ready_o;
  assign sum         = ram_rdata_i + data_q;
  assign ovf         = ram_rdata_i[31] == data_q[31] && sum[31] != data_q[31];
  assign wsum        = (SAT_EN && ovf) ? (data_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
  // next-state and request/drain bookkeeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    first_d = first_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = drain_base_i;
          rem_d   = drain_len_i;
          sat_d   = 1'b0;
          state_d = drain_len_i == 12'd0 ? DR_DONE : DR_RD;
        end else if (acc_hs) begin
          idx_d   = acc_idx_i;
          data_d  = acc_data_i;
          first_d = acc_first_i;
          state_d = acc_first_i ? ACC_WR : ACC_RD;
        end
      end
      ACC_RD:  state_d = ACC_WR;
      ACC_WR: begin
        sat_d   = sat_q | (!first_q & ovf);
        state_d = IDLE;
      end
      DR_RD:   state_d = DR_OUT;
      DR_OUT: begin
        if (out_ready_i) begin
          ptr_d   = ptr_q + 11'd1;
          rem_d   = rem_q - 12'd1;
          state_d = rem_q == 12'd1 ? DR_DONE : DR_RD;
        end
      end
      DR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // RAM port and status outputs decoded from the current state
  always_comb begin
    ram_en_o     = state_q inside {ACC_RD, ACC_WR, DR_RD};
    ram_we_o     = state_q == ACC_WR;
    ram_r_addr_o = state_q == ACC_RD ? {idx_q, 2'b00} : state_q == DR_RD ? {ptr_q, 2'b00} : 13'd0;
    ram_w_addr_o = ram_we_o ? {idx_q, 2'b00} : 13'd0;
    ram_wdata_o  = !ram_we_o ? 32'd0 : first_q ? data_q : wsum;
    out_valid_o  = state_q == DR_OUT;
    out_data_o   = ent_q ? ram_rdata_i : hold_q;
    drain_busy_o = state_q inside {DR_RD, DR_OUT};
    drain_done_o = state_q == DR_DONE;
    sat_o        = sat_q;
  end
  // state registers; read data is passed through on DR_OUT entry and held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      ent_q   <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      first_q <= 1'b0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      ent_q   <= state_q == DR_RD;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      first_q <= first_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
      if (ent_q) hold_q <= ram_rdata_i;
    end
  end
endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: directed scoreboard bench for acc_ctrl (saturating and wrapping instances)
module tb_acc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_valid_i = 1'b0, acc_first_i = 1'b0, drain_start_i = 1'b0, out_ready_i = 1'b1;
  logic [10:0] acc_idx_i = '0, drain_base_i = '0;
  logic [31:0] acc_data_i = '0;
  logic [11:0] drain_len_i = '0;
  logic        acc_ready_o, drain_busy_o, drain_done_o, out_valid_o, ram_en_o, ram_we_o, sat_o;
  logic [31:0] out_data_o, ram_wdata_o, ram_rdata_i = '0;
  logic [12:0] ram_w_addr_o, ram_r_addr_o;
  logic        acc_ready2, drain_busy2, drain_done2, out_valid2, ram_en2, ram_we2, sat2;
  logic [31:0] out_data2, ram_wdata2, ram_rdata2 = '0;
  logic [12:0] ram_w_addr2, ram_r_addr2;
  logic [31:0] mem [2048];
  logic [31:0] mem2 [2048];
  int          checks = 0, errors = 0, done_cnt = 0;
  logic [44:0] wq[$];
  logic [31:0] oq[$];
  bit          tog = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] prev = '0;

  always #5 clk = ~clk;

  acc_ctrl #(.SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .acc_idx_i(acc_idx_i), .acc_data_i(acc_data_i), .acc_first_i(acc_first_i),
    .drain_start_i(drain_start_i), .drain_base_i(drain_base_i), .drain_len_i(drain_len_i),
    .drain_busy_o(drain_busy_o), .drain_done_o(drain_done_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_w_addr_o(ram_w_addr_o), .ram_r_addr_o(ram_r_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .sat_o(sat_o));

  acc_ctrl #(.SAT_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready2),
    .acc_idx_i(acc_idx_i), .acc_data_i(acc_data_i), .acc_first_i(acc_first_i),
    .drain_start_i(drain_start_i), .drain_base_i(drain_base_i), .drain_len_i(drain_len_i),
    .drain_busy_o(drain_busy2), .drain_done_o(drain_done2), .out_valid_o(out_valid2),
    .out_ready_i(out_ready_i), .out_data_o(out_data2), .ram_en_o(ram_en2), .ram_we_o(ram_we2),
    .ram_w_addr_o(ram_w_addr2), .ram_r_addr_o(ram_r_addr2), .ram_wdata_o(ram_wdata2),
    .ram_rdata_i(ram_rdata2), .sat_o(sat2));

  // one-cycle-latency RAM models
  always @(posedge clk) begin
    if (ram_en_o && ram_we_o) mem[ram_w_addr_o[12:2]] <= ram_wdata_o;
    if (ram_en_o && !ram_we_o) ram_rdata_i <= mem[ram_r_addr_o[12:2]];
    if (ram_en2 && ram_we2) mem2[ram_w_addr2[12:2]] <= ram_wdata2;
    if (ram_en2 && !ram_we2) ram_rdata2 <= mem2[ram_r_addr2[12:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // out_ready either held high or toggled every cycle
  initial forever begin
    @(posedge clk);
    #1 out_ready_i = tog ? ~out_ready_i : 1'b1;
  end

  // monitor: pops expected writes / drained words when the DUT presents them
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en_o && ram_we_o) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", ram_w_addr_o, ram_wdata_o);
        end else begin
          logic [44:0] e;
          e = wq.pop_front();
          chk("wr_addr", {19'd0, ram_w_addr_o}, {19'd0, e[44:32]});
          chk("wr_data", ram_wdata_o, e[31:0]);
        end
      end
      if (out_valid_o) begin
        if (stall) chk("out_stable", out_data_o, prev);
        if (out_ready_i) begin
          if (oq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected no word", out_data_o);
          end else chk("out_data", out_data_o, oq.pop_front());
        end
      end
      stall = out_valid_o && !out_ready_i;
      prev  = out_data_o;
      if (drain_done_o) begin
        done_cnt++;
        chk("done_busy", {31'd0, drain_busy_o}, 32'd0);
      end
    end else stall = 1'b0;
  end

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!acc_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, acc_ready_o}, 32'd1);
  endtask

  task automatic acc(input bit first, input logic [10:0] idx, input logic [31:0] data, input logic [31:0] exp);
    wq.push_back({idx, 2'b00, exp});
    @(posedge clk);
    #1;
    acc_valid_i = 1'b1;
    acc_first_i = first;
    acc_idx_i   = idx;
    acc_data_i  = data;
    wait_rdy();
    @(posedge clk);
    #1 acc_valid_i = 1'b0;
    @(negedge clk);
    if (!first) begin
      chk("acc_rd", {17'd0, ram_en_o, ram_we_o, ram_r_addr_o}, {17'd0, 2'b10, idx, 2'b00});
      @(negedge clk);
    end
    chk("acc_wr", {17'd0, ram_en_o, ram_we_o, ram_w_addr_o}, {17'd0, 2'b11, idx, 2'b00});
    @(negedge clk);
    chk("acc_idle", {31'd0, acc_ready_o}, 32'd1);
  endtask

  task automatic drain(input logic [10:0] base, input logic [11:0] len, input bit t);
    int n = 0;
    int d0;
    @(posedge clk);
    #1;
    tog           = t;
    drain_start_i = 1'b1;
    drain_base_i  = base;
    drain_len_i   = len;
    d0            = done_cnt;
    @(posedge clk);
    #1 drain_start_i = 1'b0;
    @(negedge clk);
    chk("drain_sat_clr", {31'd0, sat_o}, 32'd0);
    chk("drain_busy", {31'd0, drain_busy_o}, {31'd0, len != 12'd0});
    if (len == 12'd0) begin
      chk("len0_done", {31'd0, drain_done_o}, 32'd1);
      chk("len0_no_ram", {31'd0, ram_en_o}, 32'd0);
    end
    while (!drain_done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done_timeout", {31'd0, drain_done_o}, 32'd1);
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, 32'd1);
    chk("drain_words_left", oq.size(), 32'd0);
    chk("after_drain_idle", {31'd0, acc_ready_o}, 32'd1);
    tog = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  bad;
    // reset state
    #12;
    chk("rst_outs", {25'd0, acc_ready_o, ram_en_o, ram_we_o, sat_o, drain_busy_o, drain_done_o, out_valid_o}, 32'd0);
    chk("rst_data", out_data_o, 32'd0);
    #10 rst_n = 1'b1;
    #1 chk("rdy_before_edge", {31'd0, acc_ready_o}, 32'd0);
    @(negedge clk);
    chk("rdy_after_edge", {31'd0, acc_ready_o}, 32'd1);
    // basic accumulate: 10 + (-3) = 7
    acc(1'b1, 11'd5, 32'd10, 32'd10);
    acc(1'b0, 11'd5, 32'hFFFF_FFFD, 32'd7);
    chk("basic_sat", {31'd0, sat_o}, 32'd0);
    // positive saturation vs wrap
    acc(1'b1, 11'd9, 32'h7FFF_FFF0, 32'h7FFF_FFF0);
    acc(1'b0, 11'd9, 32'h0000_0020, 32'h7FFF_FFFF);
    chk("sat_flag", {31'd0, sat_o}, 32'd1);
    chk("wrap_word", mem2[9], 32'h8000_0010);
    chk("wrap_sat", {31'd0, sat2}, 32'd1);
    // negative saturation
    acc(1'b1, 11'd10, 32'h8000_0010, 32'h8000_0010);
    acc(1'b0, 11'd10, 32'hFFFF_FFE0, 32'h8000_0000);
    // drain across the index wrap with a stalling consumer
    acc(1'b1, 11'd2046, 32'h11, 32'h11);
    acc(1'b1, 11'd2047, 32'h22, 32'h22);
    acc(1'b1, 11'd0, 32'h33, 32'h33);
    oq.push_back(32'h11);
    oq.push_back(32'h22);
    oq.push_back(32'h33);
    drain(11'd2046, 12'd3, 1'b1);
    // drain_start beats a simultaneous accumulate request
    wq.push_back({11'd20, 2'b00, 32'h44});
    oq.push_back(32'd7);
    @(posedge clk);
    #1;
    acc_valid_i   = 1'b1;
    acc_first_i   = 1'b1;
    acc_idx_i     = 11'd20;
    acc_data_i    = 32'h44;
    drain_start_i = 1'b1;
    drain_base_i  = 11'd5;
    drain_len_i   = 12'd1;
    @(negedge clk);
    chk("prio_rdy0", {31'd0, acc_ready_o}, 32'd0);
    @(posedge clk);
    #1 drain_start_i = 1'b0;
    n   = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      if (acc_ready_o) bad = 1'b1;
      n++;
    end while (!drain_done_o && n < 50);
    chk("prio_hold", {31'd0, bad}, 32'd0);
    chk("prio_done", {31'd0, drain_done_o}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1 acc_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_acc_written", wq.size(), 32'd0);
    chk("prio_word20", mem[20], 32'h44);
    chk("prio_out_left", oq.size(), 32'd0);
    // zero-length drain
    drain(11'd100, 12'd0, 1'b0);
    // reset in the middle of a read-modify-write
    @(posedge clk);
    #1;
    acc_valid_i = 1'b1;
    acc_first_i = 1'b0;
    acc_idx_i   = 11'd5;
    acc_data_i  = 32'd100;
    wait_rdy();
    @(posedge clk);
    #1 acc_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd", {17'd0, ram_en_o, ram_we_o, ram_r_addr_o}, {17'd0, 2'b10, 11'd5, 2'b00});
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outs", {25'd0, acc_ready_o, ram_en_o, ram_we_o, sat_o, drain_busy_o, drain_done_o, out_valid_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdy", {31'd0, acc_ready_o}, 32'd1);
    chk("rst_mid_word", mem[5], 32'd7);
    chk("rst_mid_wq", wq.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
